// File: rtl/hazard_scoreboard_if.sv
// Fetch-to-execute channel of the hazard scoreboard: instruction in, issued instruction out,
// combinational hold request back to fetch, pipeline flush and the stall statistic.
interface hazard_scoreboard_if #(
    parameter int unsigned INSTR_W = 24
);
    logic               flush;
    logic               instr_valid;
    logic [INSTR_W-1:0] instruction_in;
    logic [INSTR_W-1:0] instruction_out;
    logic               issue_valid;
    logic               fetch_next;
    logic [15:0]        stall_count;

    modport master (
        output flush, instr_valid, instruction_in,
        input  instruction_out, issue_valid, fetch_next, stall_count
    );

    modport slave (
        input  flush, instr_valid, instruction_in,
        output instruction_out, issue_valid, fetch_next, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Read-after-write hazard unit: one countdown per architectural register tracks in-flight
// writes; a reader of a pending register holds fetch and sends a bubble to execute.
module hazard_scoreboard #(
    parameter int unsigned       INSTR_W = 24,
    parameter int unsigned       OPC_W   = 6,
    parameter int unsigned       REG_W   = 2,
    parameter int unsigned       SRC_W   = 4,
    parameter int unsigned       LAT     = 2,
    parameter bit                FORWARD = 1'b0,
    parameter logic [OPC_W-1:0]  LI_OPC  = '0
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave bus
);
    localparam int unsigned NREGS  = 2 ** REG_W;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned RD_LSB = INSTR_W - OPC_W - REG_W;
    localparam int unsigned RS_LSB = INSTR_W - OPC_W - REG_W - SRC_W;
    localparam logic [15:0] SAT    = 16'hFFFF;

    logic [CNT_W-1:0] cnt [NREGS];
    logic [OPC_W-1:0] opc;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs;
    logic             is_li;
    logic             hazard;

    // With a bypass path the final countdown cycle can already be forwarded.
    function automatic logic pending(input logic [CNT_W-1:0] c);
        return FORWARD ? (c > CNT_W'(1)) : (c != CNT_W'(0));
    endfunction

    assign opc   = bus.instruction_in[INSTR_W-1 -: OPC_W];
    assign rd    = bus.instruction_in[RD_LSB +: REG_W];
    assign rs    = bus.instruction_in[RS_LSB +: REG_W];
    assign is_li = (opc == LI_OPC);

    always_comb begin
        hazard = 1'b0;
        if (bus.instr_valid && !bus.flush && !rst && !is_li)
            hazard = pending(cnt[rd]) || pending(cnt[rs]);
    end

    assign bus.fetch_next = hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
            bus.instruction_out <= '0;
            bus.issue_valid     <= 1'b0;
            bus.stall_count     <= '0;
        end else if (bus.flush) begin
            // Redirect: forget in-flight writes and drop the presented instruction.
            for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
            bus.instruction_out <= '0;
            bus.issue_valid     <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++)
                if (cnt[r] != CNT_W'(0)) cnt[r] <= cnt[r] - CNT_W'(1);
            if (bus.instr_valid && !hazard) begin
                cnt[rd]             <= CNT_W'(LAT);
                bus.instruction_out <= bus.instruction_in;
                bus.issue_valid     <= 1'b1;
            end else begin
                bus.instruction_out <= '0;
                bus.issue_valid     <= 1'b0;
            end
            if (hazard && bus.stall_count != SAT)
                bus.stall_count <= bus.stall_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: four configurations driven from per-DUT stimulus
// arrays, every output compared against hand-derived expectations.
module tb_hazard_scoreboard;
    localparam int unsigned ND = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [ND-1:0] vld;
    logic [ND-1:0] fl;
    logic [23:0]   ins  [ND];
    logic [23:0]   iout [ND];
    logic          ivld [ND];
    logic          fn   [ND];
    logic [15:0]   sc   [ND];

    int errors = 0;
    int checks = 0;

    hazard_scoreboard_if #(.INSTR_W(24)) bus0 ();
    hazard_scoreboard_if #(.INSTR_W(24)) bus1 ();
    hazard_scoreboard_if #(.INSTR_W(24)) bus2 ();
    hazard_scoreboard_if #(.INSTR_W(24)) bus3 ();

    assign bus0.instr_valid = vld[0]; assign bus0.flush = fl[0]; assign bus0.instruction_in = ins[0];
    assign bus1.instr_valid = vld[1]; assign bus1.flush = fl[1]; assign bus1.instruction_in = ins[1];
    assign bus2.instr_valid = vld[2]; assign bus2.flush = fl[2]; assign bus2.instruction_in = ins[2];
    assign bus3.instr_valid = vld[3]; assign bus3.flush = fl[3]; assign bus3.instruction_in = ins[3];

    assign iout[0] = bus0.instruction_out; assign ivld[0] = bus0.issue_valid;
    assign fn[0]   = bus0.fetch_next;      assign sc[0]   = bus0.stall_count;
    assign iout[1] = bus1.instruction_out; assign ivld[1] = bus1.issue_valid;
    assign fn[1]   = bus1.fetch_next;      assign sc[1]   = bus1.stall_count;
    assign iout[2] = bus2.instruction_out; assign ivld[2] = bus2.issue_valid;
    assign fn[2]   = bus2.fetch_next;      assign sc[2]   = bus2.stall_count;
    assign iout[3] = bus3.instruction_out; assign ivld[3] = bus3.issue_valid;
    assign fn[3]   = bus3.fetch_next;      assign sc[3]   = bus3.stall_count;

    hazard_scoreboard #(.LAT(2),  .FORWARD(1'b0)) u_def  (.clk(clk), .rst(rst), .bus(bus0.slave));
    hazard_scoreboard #(.LAT(2),  .FORWARD(1'b1)) u_fwd  (.clk(clk), .rst(rst), .bus(bus1.slave));
    hazard_scoreboard #(.LAT(4),  .FORWARD(1'b0)) u_lat4 (.clk(clk), .rst(rst), .bus(bus2.slave));
    hazard_scoreboard #(.LAT(15), .FORWARD(1'b0)) u_lat15(.clk(clk), .rst(rst), .bus(bus3.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic present(input int d, input logic v, input logic [23:0] i, input logic f);
        vld[d] = v;
        ins[d] = i;
        fl[d]  = f;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [23:0] prog [4];
    logic [23:0] li_r1;
    logic [23:0] rd_r1;

    initial begin
        prog[0] = 24'b000000_00_0100_000000000100;
        prog[1] = 24'b000100_01_0011_000000000110;
        prog[2] = 24'b000011_00_0110_000000001000;
        prog[3] = 24'b000100_10_0011_000000000110;
        li_r1   = {6'd0, 2'd1, 4'd0, 12'd0};
        rd_r1   = {6'd4, 2'd0, 4'd1, 12'd0};

        // Reset held two cycles with a valid instruction presented everywhere.
        rst = 1'b1;
        for (int d = 0; d < ND; d++) present(d, 1'b1, prog[1], 1'b0);
        chk("rst_fetch_next", 32'(fn[0]), 32'd0);
        tick();
        tick();
        for (int d = 0; d < ND; d++) begin
            chk("rst_issue_valid", 32'(ivld[d]), 32'd0);
            chk("rst_instr_out", 32'(iout[d]), 32'd0);
            chk("rst_stall_count", 32'(sc[d]), 32'd0);
        end
        rst = 1'b0;
        for (int d = 1; d < ND; d++) present(d, 1'b0, 24'd0, 1'b0);

        // Default config: I2 reads r0 one cycle after I0 wrote it.
        present(0, 1'b1, prog[0], 1'b0); chk("def_fn_i0", 32'(fn[0]), 32'd0);
        tick(); chk("def_iss_i0", 32'(ivld[0]), 32'd1); chk("def_out_i0", 32'(iout[0]), 32'(prog[0]));
        present(0, 1'b1, prog[1], 1'b0); chk("def_fn_i1", 32'(fn[0]), 32'd0);
        tick(); chk("def_iss_i1", 32'(ivld[0]), 32'd1); chk("def_out_i1", 32'(iout[0]), 32'(prog[1]));
        present(0, 1'b1, prog[2], 1'b0); chk("def_fn_i2_stall", 32'(fn[0]), 32'd1);
        tick(); chk("def_bubble_valid", 32'(ivld[0]), 32'd0); chk("def_bubble_out", 32'(iout[0]), 32'd0);
        chk("def_sc_after_stall", 32'(sc[0]), 32'd1);
        present(0, 1'b1, prog[2], 1'b0); chk("def_fn_i2_go", 32'(fn[0]), 32'd0);
        tick(); chk("def_iss_i2", 32'(ivld[0]), 32'd1); chk("def_out_i2", 32'(iout[0]), 32'(prog[2]));
        present(0, 1'b1, prog[3], 1'b0); chk("def_fn_i3", 32'(fn[0]), 32'd0);
        tick(); chk("def_iss_i3", 32'(ivld[0]), 32'd1); chk("def_out_i3", 32'(iout[0]), 32'(prog[3]));
        chk("def_sc_final", 32'(sc[0]), 32'd1);
        present(0, 1'b0, prog[3], 1'b0);
        tick(); chk("def_idle_valid", 32'(ivld[0]), 32'd0); chk("def_idle_out", 32'(iout[0]), 32'd0);

        // Forwarding: same program runs back to back.
        for (int k = 0; k < 4; k++) begin
            present(1, 1'b1, prog[k], 1'b0);
            chk("fwd_fn", 32'(fn[1]), 32'd0);
            tick();
            chk("fwd_iss", 32'(ivld[1]), 32'd1);
            chk("fwd_out", 32'(iout[1]), 32'(prog[k]));
        end
        chk("fwd_sc", 32'(sc[1]), 32'd0);
        present(1, 1'b0, 24'd0, 1'b0);

        // LAT=4: immediate reader of r1 waits out cnt 4,3,2,1.
        present(2, 1'b1, li_r1, 1'b0);
        tick(); chk("lat4_iss_li", 32'(ivld[2]), 32'd1);
        for (int k = 0; k < 4; k++) begin
            present(2, 1'b1, rd_r1, 1'b0);
            chk("lat4_fn_stall", 32'(fn[2]), 32'd1);
            tick();
            chk("lat4_bubble", 32'(ivld[2]), 32'd0);
        end
        present(2, 1'b1, rd_r1, 1'b0); chk("lat4_fn_go", 32'(fn[2]), 32'd0);
        tick(); chk("lat4_iss_rd", 32'(ivld[2]), 32'd1); chk("lat4_out_rd", 32'(iout[2]), 32'(rd_r1));
        chk("lat4_sc", 32'(sc[2]), 32'd4);
        present(2, 1'b0, 24'd0, 1'b0);

        // Flush in a stalled cycle drops the reader and clears the scoreboard.
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst2_sc", 32'(sc[0]), 32'd0);
        present(0, 1'b1, li_r1, 1'b0);
        tick(); chk("fl_iss_li", 32'(ivld[0]), 32'd1);
        present(0, 1'b1, rd_r1, 1'b0); chk("fl_fn_stall", 32'(fn[0]), 32'd1);
        tick(); chk("fl_bubble", 32'(ivld[0]), 32'd0); chk("fl_sc_pre", 32'(sc[0]), 32'd1);
        present(0, 1'b1, rd_r1, 1'b1); chk("fl_fn_masked", 32'(fn[0]), 32'd0);
        tick(); chk("fl_dropped_valid", 32'(ivld[0]), 32'd0); chk("fl_dropped_out", 32'(iout[0]), 32'd0);
        chk("fl_sc_kept", 32'(sc[0]), 32'd1);
        present(0, 1'b1, rd_r1, 1'b0); chk("fl_fn_after", 32'(fn[0]), 32'd0);
        tick(); chk("fl_iss_rd", 32'(ivld[0]), 32'd1); chk("fl_out_rd", 32'(iout[0]), 32'(rd_r1));
        chk("fl_sc_final", 32'(sc[0]), 32'd1);
        present(0, 1'b0, 24'd0, 1'b0);

        // Saturation on LAT=15: 15 stalls per producer, 4370 rounds exceed 16'hFFFF.
        for (int p = 0; p < 4370; p++) begin
            present(3, 1'b1, li_r1, 1'b0);
            tick();
            for (int k = 0; k < 15; k++) begin
                present(3, 1'b1, rd_r1, 1'b0);
                if (p == 0 && k == 14) chk("sat_fn_last", 32'(fn[3]), 32'd1);
                tick();
            end
            if (p == 0) chk("sat_sc_first", 32'(sc[3]), 32'd15);
        end
        chk("sat_sc_hold", 32'(sc[3]), 32'hFFFF);
        present(3, 1'b1, li_r1, 1'b0);
        tick();
        present(3, 1'b1, rd_r1, 1'b0); chk("sat_fn_stall", 32'(fn[3]), 32'd1);
        chk("sat_sc_still", 32'(sc[3]), 32'hFFFF);
        rst = 1'b1; #1;
        chk("sat_fn_in_rst", 32'(fn[3]), 32'd0);
        tick();
        chk("sat_sc_rst", 32'(sc[3]), 32'd0); chk("sat_iss_rst", 32'(ivld[3]), 32'd0);
        rst = 1'b0;
        present(3, 1'b1, rd_r1, 1'b0); chk("sat_fn_released", 32'(fn[3]), 32'd0);
        tick(); chk("sat_iss_after", 32'(ivld[3]), 32'd1); chk("sat_out_after", 32'(iout[3]), 32'(rd_r1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
